// File: rtl/bldc_drive_sequencer.sv
// bldc_drive_sequencer: start-up and speed-profile controller for the BLDC ESC.
// Latency: profile outputs change 1 clk after the tick cycle. The tune_sel copy lags 1 clk.
// Backpressure: none. The block is tick-paced and samples level inputs, with no handshake.
//
// Ports:
//   clk_i, reset_i          clock and asynchronous active-high reset
//   start_i                 run request (level)
//   target_mag_i/_dir_i     requested reference magnitude and direction (1 = reverse)
//   ramp_step_i             magnitude change per tick (0 freezes the ramp)
//   tune_sel_i              PID tuner select, copied to tunerreset_autotune_o[2:0]
//   period_speed_i          measured period from the ESC (used for stall detection)
//   pwm_en_o                ESC PWM enable
//   period_reference_o      two's-complement reference: dir ? -mag : mag
//   tunerreset_autotune_o   {tuner reset, tune_sel}
//   state_o, busy_o, fault_o  status
//
// Optional feature: define BLDC_SEQ_STALL_DETECT_EN to enable stall detection.
// When enabled, STALL_TICKS consecutive zero-speed ticks in RAMP/RUN force FAULT.
module bldc_drive_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int TICK_DIV    = 1024,
   parameter int ALIGN_TICKS = 64,
   parameter int ALIGN_MAG   = 16,
   parameter int STALL_TICKS = 256
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-2:0] target_mag_i,
   input  logic                  target_dir_i,
   input  logic [7:0]            ramp_step_i,
   input  logic [2:0]            tune_sel_i,
   input  logic [DATA_WIDTH-1:0] period_speed_i,
   output logic                  pwm_en_o,
   output logic [DATA_WIDTH-1:0] period_reference_o,
   output logic [3:0]            tunerreset_autotune_o,
   output logic [2:0]            state_o,
   output logic                  busy_o,
   output logic                  fault_o
);

   localparam int MW = DATA_WIDTH - 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (ALIGN_TICKS > 1) ? $clog2(ALIGN_TICKS + 1) : 1;
   localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ALIGN_LAST  = AW'(ALIGN_TICKS - 1);
   localparam logic [MW-1:0] ALIGN_MAG_V = MW'(ALIGN_MAG);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ALIGN   = 3'd1,
      S_RAMP    = 3'd2,
      S_RUN     = 3'd3,
      S_REVERSE = 3'd4,
      S_DECEL   = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   // One slew-limited step from cur toward tgt, clamped so it never passes tgt.
   // The up path keeps a carry bit so cur+step cannot wrap.
   function automatic logic [MW-1:0] step_toward(input logic [MW-1:0] cur,
                                                 input logic [MW-1:0] tgt,
                                                 input logic [7:0]    stp);
      logic [MW:0]   sum;
      logic [MW-1:0] stp_w;
      logic [MW-1:0] gap;
      stp_w = MW'(stp);
      sum   = {1'b0, cur} + {1'b0, stp_w};
      gap   = cur - tgt;
      if (cur < tgt) begin
         step_toward = (sum >= {1'b0, tgt}) ? tgt : sum[MW-1:0];
      end else if (gap <= stp_w) begin
         step_toward = tgt;
      end else begin
         step_toward = cur - stp_w;
      end
   endfunction

   // Prescaler: free-running, tick on the last count.
   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   assign tick  = (pre_q == TICK_LAST);
   assign pre_d = tick ? '0 : pre_q + PW'(1);

   state_t        state_q, state_d;
   logic [MW-1:0] mag_q, mag_d;
   logic          dir_q, dir_d;
   logic [AW-1:0] acnt_q, acnt_d;
   logic          dir_match;
   logic          fault_now;

`ifdef BLDC_SEQ_STALL_DETECT_EN
   localparam int SW = $clog2(STALL_TICKS + 1);
   localparam logic [SW-1:0] STALL_LIM = SW'(STALL_TICKS);
   logic [SW-1:0] stall_q, stall_d;
`else
   logic unused_speed;
   assign unused_speed = ^{period_speed_i, 32'(STALL_TICKS)};
`endif

   // Next state and profile registers. Everything moves only on tick.
   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      dir_d     = dir_q;
      acnt_d    = acnt_q;
      fault_now = 1'b0;
      dir_match = (target_dir_i == dir_q);
`ifdef BLDC_SEQ_STALL_DETECT_EN
      stall_d = stall_q;
      if (tick && (state_q == S_RAMP || state_q == S_RUN)) begin
         if (period_speed_i == '0) begin
            stall_d   = stall_q + SW'(1);
            fault_now = (stall_d >= STALL_LIM);
         end else begin
            stall_d = '0;
         end
      end
`endif
      if (tick) begin
         if (fault_now) begin
            state_d = S_FAULT;
            mag_d   = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  mag_d = '0;
                  if (start_i) begin
                     dir_d   = target_dir_i;
                     acnt_d  = '0;
                     mag_d   = ALIGN_MAG_V;
                     state_d = S_ALIGN;
                  end
               end
               S_ALIGN: begin
                  if (!start_i) begin
                     state_d = S_DECEL;
                  end else if (acnt_q == ALIGN_LAST) begin
                     // Alignment drive is not a speed: the ramp begins from
                     // standstill and takes its first step on this tick.
                     state_d = S_RAMP;
                     mag_d   = dir_match ? step_toward('0, target_mag_i, ramp_step_i) : '0;
                  end else begin
                     acnt_d = acnt_q + AW'(1);
                  end
               end
               S_RAMP: begin
                  if (!start_i) begin
                     state_d = S_DECEL;
                  end else if (!dir_match) begin
                     state_d = S_REVERSE;
                  end else if (mag_q == target_mag_i) begin
                     state_d = S_RUN;
                  end else begin
                     mag_d = step_toward(mag_q, target_mag_i, ramp_step_i);
                  end
               end
               S_RUN: begin
                  if (!start_i) begin
                     state_d = S_DECEL;
                  end else if (!dir_match) begin
                     state_d = S_REVERSE;
                  end else if (mag_q != target_mag_i) begin
                     state_d = S_RAMP;
                  end
               end
               S_REVERSE: begin
                  if (!start_i) begin
                     state_d = S_DECEL;
                  end else if (mag_q == '0) begin
                     dir_d   = ~dir_q;
                     acnt_d  = '0;
                     mag_d   = ALIGN_MAG_V;
                     state_d = S_ALIGN;
                  end else begin
                     mag_d = step_toward(mag_q, '0, ramp_step_i);
                  end
               end
               S_DECEL: begin
                  if (start_i) begin
                     state_d = S_RAMP;
                  end else if (mag_q == '0) begin
                     state_d = S_IDLE;
                  end else begin
                     mag_d = step_toward(mag_q, '0, ramp_step_i);
                  end
               end
               S_FAULT: begin
                  mag_d = '0;
`ifdef BLDC_SEQ_STALL_DETECT_EN
                  if (!start_i) begin
                     state_d = S_IDLE;
                  end
`else
                  state_d = S_IDLE;
`endif
               end
               default: begin
                  mag_d   = '0;
                  state_d = S_IDLE;
               end
            endcase
         end
      end
`ifdef BLDC_SEQ_STALL_DETECT_EN
      if (state_d != S_RAMP && state_d != S_RUN) begin
         stall_d = '0;
      end
`endif
   end

   // Output next values, derived from next state so outputs land with the tick edge.
   logic [DATA_WIDTH-1:0] mag_ext;
   logic [DATA_WIDTH-1:0] ref_d;
   logic                  pwm_d;
   logic                  busy_d;
   logic                  trst_d;
   logic                  fault_d;

   always_comb begin
      mag_ext = {1'b0, mag_d};
      ref_d   = dir_d ? -mag_ext : mag_ext;
      pwm_d   = 1'b0;
      busy_d  = 1'b0;
      trst_d  = 1'b1;
      fault_d = 1'b0;
      case (state_d)
         S_ALIGN: begin
            pwm_d  = 1'b1;
            busy_d = 1'b1;
         end
         S_RAMP, S_RUN, S_REVERSE, S_DECEL: begin
            pwm_d  = 1'b1;
            busy_d = 1'b1;
            trst_d = 1'b0;
         end
         S_FAULT: begin
            fault_d = 1'b1;
         end
         default: begin
            pwm_d = 1'b0;
         end
      endcase
   end

   logic                  pwm_q;
   logic [DATA_WIDTH-1:0] ref_q;
   logic [3:0]            trst_q;
   logic                  busy_q;
   logic                  fault_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pre_q   <= '0;
         state_q <= S_IDLE;
         mag_q   <= '0;
         dir_q   <= 1'b0;
         acnt_q  <= '0;
         pwm_q   <= 1'b0;
         ref_q   <= '0;
         trst_q  <= 4'b1000;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
`ifdef BLDC_SEQ_STALL_DETECT_EN
         stall_q <= '0;
`endif
      end else begin
         pre_q   <= pre_d;
         state_q <= state_d;
         mag_q   <= mag_d;
         dir_q   <= dir_d;
         acnt_q  <= acnt_d;
         pwm_q   <= pwm_d;
         ref_q   <= ref_d;
         trst_q  <= {trst_d, tune_sel_i};
         busy_q  <= busy_d;
         fault_q <= fault_d;
`ifdef BLDC_SEQ_STALL_DETECT_EN
         stall_q <= stall_d;
`endif
      end
   end

   assign pwm_en_o              = pwm_q;
   assign period_reference_o    = ref_q;
   assign tunerreset_autotune_o = trst_q;
   assign state_o               = state_q;
   assign busy_o                = busy_q;
`ifdef BLDC_SEQ_STALL_DETECT_EN
   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
   logic unused_fault;
   assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// tb_bldc_drive_sequencer: scoreboard bench for bldc_drive_sequencer.
// Latency: one expected entry per profile tick, compared 1 clk after the tick cycle.
// Backpressure: none.
module tb_bldc_drive_sequencer;

   localparam int TD = 4;
   localparam int AT = 2;
   localparam int AM = 16;
   localparam int ST = 3;

   typedef struct packed {
      logic [2:0]  st;
      logic [15:0] rf;
      logic        pwm;
      logic [3:0]  tr;
      logic        busy;
      logic        flt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        tdir;
   logic [14:0] tmag;
   logic [7:0]  rstep;
   logic [2:0]  tsel;
   logic [15:0] spd;
   logic        pwm;
   logic [15:0] pref;
   logic [3:0]  tra;
   logic [2:0]  state;
   logic        busy;
   logic        fault;

   always #5 clk = ~clk;

   bldc_drive_sequencer #(
      .DATA_WIDTH (16),
      .TICK_DIV   (TD),
      .ALIGN_TICKS(AT),
      .ALIGN_MAG  (AM),
      .STALL_TICKS(ST)
   ) dut (
      .clk_i                (clk),
      .reset_i              (rst),
      .start_i              (start),
      .target_mag_i         (tmag),
      .target_dir_i         (tdir),
      .ramp_step_i          (rstep),
      .tune_sel_i           (tsel),
      .period_speed_i       (spd),
      .pwm_en_o             (pwm),
      .period_reference_o   (pref),
      .tunerreset_autotune_o(tra),
      .state_o              (state),
      .busy_o               (busy),
      .fault_o              (fault)
   );

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   int m_state, m_mag, m_dir, m_acnt, m_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_mag = 0; m_dir = 0; m_acnt = 0; m_stall = 0;
   endfunction

   function automatic int toward(input int m, input int t, input int s);
      if (m < t) return (m + s > t) ? t : m + s;
      if (m - t <= s) return t;
      return m - s;
   endfunction

   // Reference behaviour of one profile tick, written from the operating rules.
   function automatic void model_tick();
      int nxt;
      bit stalled;
      nxt     = m_state;
      stalled = 1'b0;
`ifdef BLDC_SEQ_STALL_DETECT_EN
      if (m_state == 2 || m_state == 3) begin
         m_stall = (spd == 16'd0) ? m_stall + 1 : 0;
         if (m_stall >= ST) stalled = 1'b1;
      end
`endif
      if (stalled) begin
         nxt = 6; m_mag = 0;
      end else begin
         case (m_state)
            0: begin
               m_mag = 0;
               if (start) begin m_dir = int'(tdir); m_acnt = 0; m_mag = AM; nxt = 1; end
            end
            1: begin
               if (!start) nxt = 5;
               else if (m_acnt == AT - 1) begin
                  nxt   = 2;
                  m_mag = (int'(tdir) == m_dir) ? ((int'(rstep) < int'(tmag)) ? int'(rstep) : int'(tmag)) : 0;
               end else m_acnt++;
            end
            2: begin
               if (!start) nxt = 5;
               else if (int'(tdir) != m_dir) nxt = 4;
               else if (m_mag == int'(tmag)) nxt = 3;
               else m_mag = toward(m_mag, int'(tmag), int'(rstep));
            end
            3: begin
               if (!start) nxt = 5;
               else if (int'(tdir) != m_dir) nxt = 4;
               else if (m_mag != int'(tmag)) nxt = 2;
            end
            4: begin
               if (!start) nxt = 5;
               else if (m_mag == 0) begin m_dir = 1 - m_dir; m_acnt = 0; m_mag = AM; nxt = 1; end
               else m_mag = toward(m_mag, 0, int'(rstep));
            end
            5: begin
               if (start) nxt = 2;
               else if (m_mag == 0) nxt = 0;
               else m_mag = toward(m_mag, 0, int'(rstep));
            end
            6: begin
               m_mag = 0;
               if (!start) nxt = 0;
            end
            default: begin nxt = 0; m_mag = 0; end
         endcase
      end
      if (nxt != 2 && nxt != 3) m_stall = 0;
      m_state = nxt;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.st   = 3'(m_state);
      e.rf   = (m_dir != 0) ? 16'(-m_mag) : 16'(m_mag);
      e.pwm  = (m_state >= 1 && m_state <= 5);
      e.tr   = {(m_state == 0 || m_state == 1 || m_state == 6), tsel};
      e.busy = !(m_state == 0 || m_state == 6);
      e.flt  = (m_state == 6);
      return e;
   endfunction

   // Drive one tick period: push the expectation, wait for the tick edge, compare.
   task automatic step();
      exp_t e;
      int   prev;
      prev = m_state;
      model_tick();
      sb.push_back(model_out());
      repeat (TD - 1) @(posedge clk);
      #1 check("pretick_state", 32'(state), 32'(prev));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ref", 32'(pref), 32'(e.rf));
      check("pwm_en", 32'(pwm), 32'(e.pwm));
      check("tuner", 32'(tra), 32'(e.tr));
      check("busy", 32'(busy), 32'(e.busy));
      check("fault", 32'(fault), 32'(e.flt));
   endtask

   task automatic tick_chk(input int es, input int er);
      step();
      check("seq_state", 32'(state), 32'(es));
      check("seq_ref", 32'(pref), 32'(er));
   endtask

   task automatic check_reset_vals();
      check("rst_state", 32'(state), 32'(0));
      check("rst_ref", 32'(pref), 32'(0));
      check("rst_pwm", 32'(pwm), 32'(0));
      check("rst_tuner", 32'(tra), 32'(4'b1000));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_fault", 32'(fault), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; tdir = 1'b0; tmag = 15'd100; rstep = 8'd30;
      tsel = 3'd5; spd = 16'd200;
      model_reset();
      #12 check_reset_vals();
      #10 rst = 1'b0;

      // Start-up: align at +16 for two ticks, then slew 30/tick to 100.
      start = 1'b1;
      tick_chk(1, 16); tick_chk(1, 16);
      tick_chk(2, 30); tick_chk(2, 60); tick_chk(2, 90); tick_chk(2, 100);
      tick_chk(3, 100);

      // Lower target: ramp down and clamp at 45, then back up.
      tmag = 15'd45;
      tick_chk(2, 100); tick_chk(2, 70); tick_chk(2, 45); tick_chk(3, 45);
      tmag = 15'd100;
      tick_chk(2, 45); tick_chk(2, 75); tick_chk(2, 100); tick_chk(3, 100);

      // Direction reversal through zero, re-align at -16, ramp to -100.
      tdir = 1'b1;
      tick_chk(4, 100); tick_chk(4, 70); tick_chk(4, 40); tick_chk(4, 10); tick_chk(4, 0);
      tick_chk(1, 'hFFF0); tick_chk(1, 'hFFF0);
      tick_chk(2, 'hFFE2); tick_chk(2, 'hFFC4); tick_chk(2, 'hFFA6); tick_chk(2, 'hFF9C);
      tick_chk(3, 'hFF9C);

      // Stop request: decelerate to zero, then idle.
      start = 1'b0;
      tick_chk(5, 'hFF9C); tick_chk(5, 'hFFBA); tick_chk(5, 'hFFD8); tick_chk(5, 'hFFF6);
      tick_chk(5, 0); tick_chk(0, 0);
      check("idle_pwm", 32'(pwm), 32'(0));
      check("idle_trst", 32'(tra[3]), 32'(1));

`ifdef BLDC_SEQ_STALL_DETECT_EN
      // Stall: three zero-speed ticks in RUN trip FAULT, held while start stays high.
      start = 1'b1; tmag = 15'd100; rstep = 8'd100;
      tick_chk(1, 'hFFF0); tick_chk(1, 'hFFF0); tick_chk(2, 'hFF9C); tick_chk(3, 'hFF9C);
      spd = 16'd0;
      tick_chk(3, 'hFF9C); tick_chk(3, 'hFF9C); tick_chk(6, 0);
      check("stall_fault", 32'(fault), 32'(1));
      check("stall_pwm", 32'(pwm), 32'(0));
      tick_chk(6, 0); tick_chk(6, 0);
      start = 1'b0;
      tick_chk(0, 0);
      spd = 16'd200;
`endif

      // Randomised profile traffic against the reference model.
      for (int i = 0; i < 150; i++) begin
         start = ($urandom_range(0, 11) != 0);
         if ($urandom_range(0, 19) == 0) tdir = ~tdir;
         if ($urandom_range(0, 5) == 0) tmag = 15'($urandom_range(0, 300));
         if ($urandom_range(0, 7) == 0) rstep = 8'($urandom_range(0, 60));
         spd  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'd200;
         tsel = 3'($urandom_range(0, 7));
         step();
      end

      // Return to idle within a bounded number of ticks.
      start = 1'b0; rstep = 8'd60; spd = 16'd200;
      for (int i = 0; i < 40 && m_state != 0; i++) step();
      check("reach_idle", 32'(state), 32'(0));

      // Frozen ramp: step 0 holds magnitude and RAMP state, step 5 resumes.
      start = 1'b1; tdir = 1'b1; tmag = 15'd50; rstep = 8'd20;
      tick_chk(1, 'hFFF0); tick_chk(1, 'hFFF0); tick_chk(2, 'hFFEC);
      rstep = 8'd0;
      for (int i = 0; i < 10; i++) tick_chk(2, 'hFFEC);
      rstep = 8'd5;
      tick_chk(2, 'hFFE7); tick_chk(2, 'hFFE2);

      // Asynchronous reset between ticks mid-ramp.
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_vals();
      #2 rst = 1'b0;
      model_reset();
      sb.delete();
      tdir = 1'b0;
      tick_chk(1, 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bldc_drive_sequencer.md
# bldc_drive_sequencer

Start-up and speed-profile controller for the BLDC ESC. The block sits upstream of the ESC core and drives its `pwm_en`, `period_reference` and `tunerreset_autotune` inputs. It sequences the motor through alignment, a slew-limited ramp, steady run, controlled deceleration and direction reversal, and (optionally) stall shutdown. All profile updates occur on a prescaled tick so the ESC's PID loop sees bounded reference steps.

## Interface
- `DATA_WIDTH`, 16: width of `period_reference` and `period_speed`.
- `TICK_DIV`, 1024: `clk` cycles per profile tick; must be ≥2.
- `ALIGN_TICKS`, 64: ticks spent in ALIGN.
- `ALIGN_MAG`, 16: reference magnitude applied during ALIGN.
- `STALL_TICKS`, 256: consecutive zero-speed ticks that declare a stall.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  run request (level).
- `target_mag`  in  DATA_WIDTH-1  requested speed-reference magnitude.
- `target_dir`  in  1  0 = forward, 1 = reverse.
- `ramp_step`  in  8  magnitude change per tick; 0 freezes the ramp.
- `tune_sel`  in  3  PID tuner select, passed through.
- `period_speed`  in  DATA_WIDTH  measured period from the ESC.
- `pwm_en`  out  1  ESC PWM enable.
- `period_reference`  out  DATA_WIDTH  two's-complement reference: `cur_dir ? -cur_mag : cur_mag`.
- `tunerreset_autotune`  out  4  bit 3 is the tuner reset; bits [2:0] are `tune_sel`.
- `state`  out  3  current FSM state code.
- `busy`  out  1  high in any state except IDLE and FAULT.
- `fault`  out  1  high in FAULT.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` is asserted when the count equals TICK_DIV-1. The prescaler free-runs from reset.
- All FSM transitions and `cur_mag` / `cur_dir` updates happen only on `tick`. Inputs are sampled on that cycle.
- States:
  - IDLE=0: `pwm_en=0`, `cur_mag=0`, tuner reset=1. If `start`, load `cur_dir←target_dir` and go to ALIGN.
  - ALIGN=1: `pwm_en=1`, `cur_mag=ALIGN_MAG`, tuner reset=1. After ALIGN_TICKS ticks, go to RAMP.
  - RAMP=2: tuner reset=0.
    - Same direction: move `cur_mag` toward `target_mag` by `ramp_step`, clamped so it never overshoots. When equal, go to RUN.
    - Direction mismatch: go to REVERSE.
  - RUN=3: hold. If `target_mag≠cur_mag`, go to RAMP. If direction mismatch, go to REVERSE.
  - REVERSE=4: ramp `cur_mag` toward 0. On reaching 0, toggle `cur_dir`, reload the align counter and go to ALIGN.
  - DECEL=5: ramp toward 0. On 0, go to IDLE.
  - FAULT=6: `pwm_en=0`, `cur_mag=0`, tuner reset=1. Exit to IDLE only on a tick with `start=0`.
- `start=0` in ALIGN, RAMP, RUN or REVERSE goes to DECEL. `start=1` in DECEL goes to RAMP; direction is re-checked there.
- Arithmetic:
  - `cur_mag` is unsigned DATA_WIDTH-1 bits.
  - Up-step: `min(cur_mag+ramp_step, target)`, computed with a carry bit so it cannot wrap.
  - Down-step: `cur_mag<ramp_step ? 0 : cur_mag-ramp_step`.
- `ramp_step=0`: magnitude frozen. The FSM stays in RAMP, REVERSE or DECEL indefinitely.
- Precedence when events coincide on one tick: fault > stop (`start=0`) > direction change > magnitude change.
- Unused state code 7 goes to IDLE on the next tick.

## Timing
- All outputs are registered.
- `period_reference`, `pwm_en` and `tunerreset_autotune[3]` update on the `clk` edge that ends the tick cycle. Latency from the tick-cycle sample to the output is 1 clk.
- `tunerreset_autotune[2:0]` is a registered copy of `tune_sel`, updated every clk (not tick-gated).
- Reset values: `pwm_en=0`, `period_reference=0`, `tunerreset_autotune=4'b1000`, `state=0`, `busy=0`, `fault=0`. Prescaler, align counter and stall counter are all 0.
- Reset asserted mid-operation clears everything asynchronously. After release, the next tick occurs TICK_DIV cycles later.

## Configuration
- `BLDC_SEQ_STALL_DETECT_EN` defined:
  - In RAMP and RUN, a counter increments on each tick with `period_speed==0`. It clears on any nonzero sample and on leaving RAMP/RUN.
  - When the counter reaches STALL_TICKS, go to FAULT.
- Undefined: counter and FAULT entry logic are absent. `fault` is tied 0. FAULT is reachable only as an illegal code, which recovers to IDLE.

## Test plan
- TICK_DIV=4, ALIGN_TICKS=2, ALIGN_MAG=16, `start=1`, `target_mag=100`, `ramp_step=30`, `dir=0`:
  - ALIGN shows `period_reference=16` for 2 ticks.
  - RAMP outputs 30, 60, 90, 100, then RUN, with no overshoot.
- In RUN at 100, set `target_dir=1`:
  - REVERSE outputs 70, 40, 10, 0.
  - Then ALIGN with `period_reference=0xFFF0` (−16).
  - RAMP ends at `0xFF9C` (−100).
- In RUN, drop `start`:
  - DECEL ramps to 0 in steps of 30.
  - IDLE follows with `pwm_en=0` and `tunerreset_autotune[3]=1`.
- With `BLDC_SEQ_STALL_DETECT_EN`, STALL_TICKS=3, `period_speed=0` in RUN:
  - FAULT after 3 ticks, with `fault=1` and `pwm_en=0`.
  - Stays in FAULT while `start=1`.
  - Goes to IDLE one tick after `start=0`.
- Assert `reset` mid-RAMP between ticks:
  - Outputs return to reset values immediately, with no `clk` edge needed.
- `ramp_step=0` in RAMP with `target_mag≠cur_mag`:
  - Magnitude held and state stays 2 for 10 ticks.
  - Setting `ramp_step=5` resumes the ramp.
